// File: rtl/uart_stl_dispatcher.sv
// Byte-level bridge between the UART RX/TX byte streams and the SerialTL byte ports:
// frames 16-byte STL requests, answers pings, and serialises responses onto TX.
module uart_stl_dispatcher #(
   parameter int unsigned CLOCK_FREQ = 100_000_000,
   parameter int unsigned TIMEOUT_US = 1000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_valid_i,
   output logic       rx_ready_o,
   input  logic [7:0] rx_data_i,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic [7:0] tx_data_o,
   output logic       stl_data_valid_o,
   input  logic       stl_data_ready_i,
   output logic [7:0] stl_data_o,
   input  logic       stl_resp_valid_i,
   output logic       stl_resp_ready_o,
   input  logic [7:0] stl_resp_data_i,
   output logic [7:0] err_count_o,
   output logic       busy_o
);
   localparam int unsigned TIMEOUT_CYC = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0] HDR_STL    = 8'h53;
   localparam logic [7:0] HDR_PING   = 8'h50;
   localparam logic [7:0] PING_REPLY = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_COLLECT = 2'd1, RX_FORWARD = 2'd2} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_STL = 2'd1, TX_PING = 2'd2} tx_state_t;

   rx_state_t      rx_state_q, rx_state_d;
   tx_state_t      tx_state_q, tx_state_d;
   logic [7:0]     buf_q [16];
   logic [7:0]     buf_d [16];
   logic [3:0]     idx_q, idx_d, fidx_q, fidx_d, resp_cnt_q, resp_cnt_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           ping_pending_q, ping_pending_d;
   logic [7:0]     err_q, err_d;
   logic           rx_ready_q, rx_ready_d;
   logic           stl_valid_q, stl_valid_d;
   logic [7:0]     stl_data_q, stl_data_d;
   logic           busy_q, busy_d;
   logic           rx_accept_s, err_inc_s;

   // Next-state logic for the RX framer/forwarder and the TX arbiter.
   always_comb begin
      rx_state_d     = rx_state_q;
      tx_state_d     = tx_state_q;
      buf_d          = buf_q;
      idx_d          = idx_q;
      fidx_d         = fidx_q;
      timer_d        = timer_q;
      resp_cnt_d     = resp_cnt_q;
      ping_pending_d = ping_pending_q;
      stl_valid_d    = stl_valid_q;
      stl_data_d     = stl_data_q;
      err_inc_s      = 1'b0;
      rx_accept_s    = rx_valid_i & rx_ready_q;

      case (rx_state_q)
         RX_IDLE: begin
            if (rx_accept_s) begin
               if (rx_data_i == HDR_STL) begin
                  rx_state_d = RX_COLLECT;
                  idx_d      = 4'd0;
                  timer_d    = {TW{1'b0}};
               end else if (rx_data_i == HDR_PING) begin
                  ping_pending_d = 1'b1;
               end else begin
                  err_inc_s = 1'b1;
               end
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_COLLECT: begin
            if (rx_accept_s) begin
               buf_d[idx_q] = rx_data_i;
               idx_d        = idx_q + 4'd1;
               timer_d      = {TW{1'b0}};
               if (idx_q == 4'd15) begin
                  rx_state_d  = RX_FORWARD;
                  fidx_d      = 4'd0;
                  stl_valid_d = 1'b1;
                  stl_data_d  = buf_q[0];
               end else begin
                  rx_state_d = RX_COLLECT;
               end
            end else if (timer_q == TIMER_LAST) begin
               // stalled frame: drop what was collected
               rx_state_d = RX_IDLE;
               err_inc_s  = 1'b1;
            end else begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         RX_FORWARD: begin
            if (stl_valid_q && stl_data_ready_i) begin
               if (fidx_q == 4'd15) begin
                  rx_state_d  = RX_IDLE;
                  stl_valid_d = 1'b0;
                  stl_data_d  = 8'h00;
               end else begin
                  fidx_d     = fidx_q + 4'd1;
                  stl_data_d = buf_q[fidx_q + 4'd1];
               end
            end else begin
               rx_state_d = RX_FORWARD;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase

      case (tx_state_q)
         TX_IDLE: begin
            if (stl_resp_valid_i) begin
               tx_state_d = TX_STL;
               resp_cnt_d = 4'd0;
            end else if (ping_pending_q) begin
               tx_state_d = TX_PING;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_STL: begin
            if (stl_resp_valid_i && tx_ready_i) begin
               resp_cnt_d = resp_cnt_q + 4'd1;
               if (resp_cnt_q == 4'd15) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_state_d = TX_STL;
               end
            end else begin
               tx_state_d = TX_STL;
            end
         end
         TX_PING: begin
            if (tx_ready_i) begin
               ping_pending_d = 1'b0;
               tx_state_d     = TX_IDLE;
            end else begin
               tx_state_d = TX_PING;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase

      if (err_inc_s && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end else begin
         err_d = err_q;
      end
      rx_ready_d = (rx_state_d == RX_COLLECT) || ((rx_state_d == RX_IDLE) && !ping_pending_d);
      busy_d     = (rx_state_d != RX_IDLE) || (tx_state_d != TX_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rx_state_q     <= RX_IDLE;
         tx_state_q     <= TX_IDLE;
         buf_q          <= '{default: 8'h00};
         idx_q          <= 4'd0;
         fidx_q         <= 4'd0;
         resp_cnt_q     <= 4'd0;
         timer_q        <= {TW{1'b0}};
         ping_pending_q <= 1'b0;
         err_q          <= 8'h00;
         rx_ready_q     <= 1'b0;
         stl_valid_q    <= 1'b0;
         stl_data_q     <= 8'h00;
         busy_q         <= 1'b0;
      end else begin
         rx_state_q     <= rx_state_d;
         tx_state_q     <= tx_state_d;
         buf_q          <= buf_d;
         idx_q          <= idx_d;
         fidx_q         <= fidx_d;
         resp_cnt_q     <= resp_cnt_d;
         timer_q        <= timer_d;
         ping_pending_q <= ping_pending_d;
         err_q          <= err_d;
         rx_ready_q     <= rx_ready_d;
         stl_valid_q    <= stl_valid_d;
         stl_data_q     <= stl_data_d;
         busy_q         <= busy_d;
      end
   end

   // TX port mux: responses pass straight through while locked to STL.
   always_comb begin
      case (tx_state_q)
         TX_STL: begin
            tx_valid_o       = stl_resp_valid_i;
            tx_data_o        = stl_resp_data_i;
            stl_resp_ready_o = tx_ready_i;
         end
         TX_PING: begin
            tx_valid_o       = 1'b1;
            tx_data_o        = PING_REPLY;
            stl_resp_ready_o = 1'b0;
         end
         default: begin
            tx_valid_o       = 1'b0;
            tx_data_o        = 8'h00;
            stl_resp_ready_o = 1'b0;
         end
      endcase
   end

   assign rx_ready_o       = rx_ready_q;
   assign stl_data_valid_o = stl_valid_q;
   assign stl_data_o       = stl_data_q;
   assign err_count_o      = err_q;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_uart_stl_dispatcher.sv
// Directed-sequence bench with random payloads/backpressure, checked against a
// queue-based model of the framing, forwarding and TX merging rules.
module tb_uart_stl_dispatcher;
   localparam int TOC = 40;

   logic       clk = 1'b0;
   logic       reset_i, rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i;
   logic       stl_data_valid_o, stl_data_ready_i, stl_resp_valid_i, stl_resp_ready_o, busy_o;
   logic [7:0] rx_data_i, tx_data_o, stl_data_o, stl_resp_data_i, err_count_o;

   always #5 clk = ~clk;

   uart_stl_dispatcher #(.CLOCK_FREQ(1_000_000), .TIMEOUT_US(TOC)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
      .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
      .stl_data_valid_o(stl_data_valid_o), .stl_data_ready_i(stl_data_ready_i), .stl_data_o(stl_data_o),
      .stl_resp_valid_i(stl_resp_valid_i), .stl_resp_ready_o(stl_resp_ready_o),
      .stl_resp_data_i(stl_resp_data_i), .err_count_o(err_count_o), .busy_o(busy_o)
   );

   int tests = 0;
   int failed = 0;
   logic [7:0] got_stl[$], exp_stl[$], got_tx[$], exp_tx[$], resp_src[$], frame[$];
   bit   in_frame, accepted, prev_stall, resp_en;
   logic [7:0] prev_data;
   int   exp_err, stl_mode, tx_mode;   // modes: 0 always ready, 1 random, 2 held low

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input logic [7:0] g[$], input logic [7:0] e[$]);
      check({tag, "_count"}, g.size(), e.size());
      for (int i = 0; i < g.size() && i < e.size(); i++) check(tag, g[i], e[i]);
   endtask

   // Reference model: header decode, 16-byte frames, saturating error count.
   task automatic model_rx(input logic [7:0] b);
      if (in_frame) begin
         frame.push_back(b);
         if (frame.size() == 16) begin
            foreach (frame[i]) exp_stl.push_back(frame[i]);
            in_frame = 1'b0;
         end
      end else if (b == 8'h53) begin
         in_frame = 1'b1;
         frame.delete();
      end else if (b == 8'h50) begin
         exp_tx.push_back(8'hA5);
      end else if (exp_err < 255) begin
         exp_err++;
      end
   endtask

   task automatic model_timeout();
      if (in_frame) begin
         in_frame = 1'b0;
         frame.delete();
         if (exp_err < 255) exp_err++;
      end
   endtask

   task automatic drive();
      stl_data_ready_i = (stl_mode == 0) ? 1'b1 : (stl_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      tx_ready_i       = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      stl_resp_valid_i = resp_en && (resp_src.size() > 0);
      stl_resp_data_i  = (resp_src.size() > 0) ? resp_src[0] : 8'h00;
   endtask

   // One clock: sample just after the falling edge, then advance to the next falling edge.
   task automatic tick();
      #1;
      accepted = rx_valid_i && rx_ready_o && !reset_i;
      if (reset_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stl_hold_valid", stl_data_valid_o, 1);
            check("stl_hold_data", stl_data_o, prev_data);
         end
         if (stl_data_valid_o) begin
            check("stl_not_early", got_stl.size() < exp_stl.size(), 1);
            if (stl_data_ready_i) got_stl.push_back(stl_data_o);
         end
         prev_stall = stl_data_valid_o && !stl_data_ready_i;
         prev_data  = stl_data_o;
         if (tx_valid_o && tx_ready_i) got_tx.push_back(tx_data_o);
         if (stl_resp_valid_i && stl_resp_ready_o) void'(resp_src.pop_front());
         if (accepted) model_rx(rx_data_i);
      end
      @(posedge clk);
      @(negedge clk);
      drive();
   endtask

   task automatic send_rx(input logic [7:0] b);
      int n = 0;
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      do begin
         tick();
         n++;
      end while (!accepted && n < 200);
      check("rx_accept_bound", accepted, 1);
      rx_valid_i = 1'b0;
   endtask

   task automatic wait_stl(input int n);
      int k = 0;
      while (got_stl.size() < n && k < 1000) begin tick(); k++; end
      check("stl_wait_bound", got_stl.size() >= n, 1);
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (got_tx.size() < n && k < 1000) begin tick(); k++; end
      check("tx_wait_bound", got_tx.size() >= n, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rx_ready"}, rx_ready_o, 0);
      check({tag, "_tx_valid"}, tx_valid_o, 0);
      check({tag, "_tx_data"}, tx_data_o, 0);
      check({tag, "_stl_valid"}, stl_data_valid_o, 0);
      check({tag, "_stl_data"}, stl_data_o, 0);
      check({tag, "_resp_ready"}, stl_resp_ready_o, 0);
      check({tag, "_err"}, err_count_o, 0);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   initial begin
      reset_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
      stl_mode = 0; tx_mode = 0; resp_en = 1'b0; exp_err = 0;
      in_frame = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
      drive();
      @(negedge clk);
      repeat (3) tick();
      check_zero("reset");
      reset_i = 1'b0;
      tick();
      check("post_reset_rx_ready", rx_ready_o, 1);
      check("post_reset_busy", busy_o, 0);

      // Ping: RX blocked until the reply is handed to TX
      tx_mode = 2; drive();
      send_rx(8'h50);
      check("ping_rx_blocked", rx_ready_o, 0);
      repeat (3) tick();
      check("ping_rx_still_blocked", rx_ready_o, 0);
      check("ping_tx_valid", tx_valid_o, 1);
      check("ping_tx_data", tx_data_o, 8'hA5);
      check("ping_busy", busy_o, 1);
      tx_mode = 0; drive();
      wait_tx(1);
      check("ping_rx_reopen", rx_ready_o, 1);
      check("ping_err", err_count_o, exp_err);
      repeat (3) tick();
      cmp_q("ping_tx", got_tx, exp_tx);
      got_tx.delete(); exp_tx.delete();

      // In-order STL request with one-cycle forward latency
      send_rx(8'h53);
      for (int i = 0; i < 16; i++) send_rx(8'(i));
      check("stl_first_valid", stl_data_valid_o, 1);
      check("stl_first_data", stl_data_o, 8'h00);
      wait_stl(16);
      cmp_q("stl_inorder", got_stl, exp_stl);
      got_stl.delete(); exp_stl.delete();

      // Backpressure with random payloads and random RX gaps
      stl_mode = 1;
      for (int p = 0; p < 3; p++) begin
         send_rx(8'h53);
         for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            send_rx(8'($urandom_range(0, 255)));
         end
      end
      wait_stl(48);
      stl_mode = 0;
      cmp_q("stl_backpressure", got_stl, exp_stl);
      got_stl.delete(); exp_stl.delete();

      // Gap just below the timeout keeps the frame alive
      send_rx(8'h53);
      for (int i = 0; i < 8; i++) send_rx(8'($urandom_range(0, 255)));
      repeat (TOC - 2) tick();
      for (int i = 0; i < 8; i++) send_rx(8'($urandom_range(0, 255)));
      wait_stl(16);
      check("gap_no_err", err_count_o, exp_err);

      // Stalled frame is dropped and counted
      send_rx(8'h53);
      for (int i = 0; i < 5; i++) send_rx(8'($urandom_range(0, 255)));
      repeat (TOC + 5) tick();
      model_timeout();
      check("timeout_err", err_count_o, exp_err);
      check("timeout_rx_ready", rx_ready_o, 1);
      check("timeout_busy", busy_o, 0);
      send_rx(8'h50);
      wait_tx(1);
      repeat (3) tick();
      cmp_q("timeout_ping", got_tx, exp_tx);
      cmp_q("timeout_stl", got_stl, exp_stl);
      got_tx.delete(); exp_tx.delete(); got_stl.delete(); exp_stl.delete();

      // Unknown headers saturate the error counter
      for (int i = 0; i < 300; i++) begin
         check("bad_rx_ready", rx_ready_o, 1);
         send_rx(8'h00);
         if (i == 100) check("bad_err_mid", err_count_o, exp_err);
      end
      tick();
      check("bad_err_sat", err_count_o, 8'hFF);
      check("bad_err_model", err_count_o, exp_err);
      check("bad_rx_ready_end", rx_ready_o, 1);

      // Ping arriving mid-response waits for the whole response
      for (int i = 0; i < 16; i++) begin
         resp_src.push_back(8'($urandom_range(0, 255)));
         exp_tx.push_back(resp_src[i]);
      end
      tx_mode = 1; resp_en = 1'b1; drive();
      wait_tx(3);
      send_rx(8'h50);
      wait_tx(17);
      tx_mode = 0; resp_en = 1'b0; drive();
      repeat (3) tick();
      cmp_q("tx_lock", got_tx, exp_tx);
      check("tx_lock_resp_ready", stl_resp_ready_o, 0);
      check("tx_lock_busy", busy_o, 0);
      got_tx.delete(); exp_tx.delete();

      // Reset while a request is being forwarded
      stl_mode = 2; drive();
      send_rx(8'h53);
      for (int i = 0; i < 16; i++) send_rx(8'($urandom_range(0, 255)));
      repeat (2) tick();
      check("fwd_before_reset", stl_data_valid_o, 1);
      reset_i = 1'b1;
      repeat (2) tick();
      check_zero("mid_reset");
      exp_stl.delete(); got_stl.delete(); frame.delete();
      in_frame = 1'b0; exp_err = 0;
      reset_i = 1'b0; stl_mode = 0; drive();
      tick();
      check("after_reset_rx_ready", rx_ready_o, 1);
      check("after_reset_stl_valid", stl_data_valid_o, 0);
      send_rx(8'h53);
      for (int i = 0; i < 16; i++) send_rx(8'($urandom_range(0, 255)));
      wait_stl(16);
      repeat (3) tick();
      cmp_q("after_reset_stl", got_stl, exp_stl);
      check("after_reset_err", err_count_o, exp_err);
      cmp_q("after_reset_tx", got_tx, exp_tx);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
